// File: rtl/battle_pkg.sv
// Shared definitions for the tank battle datapath.
// Holds the shield controller state encoding and its default timing and
// charge constants so the health stage and shield controller agree on them.
package battle_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2,
    DEAD     = 2'd3
  } shield_state_t;

  localparam int SHIELD_ACTIVE_FRAMES   = 180;
  localparam int SHIELD_COOLDOWN_FRAMES = 300;
  localparam int SHIELD_HIT_LIMIT       = 2;
  localparam int SHIELD_START_CHARGES   = 3;

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector.
// Ports:
//   clock - system clock
//   reset - asynchronous active-high reset, clears the history register
//   d     - synchronous input level
//   rise  - high for the cycle in which d is high and was low last cycle
// The history register updates every cycle regardless of any consumer state.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/shield_ctrl.sv
// Per-tank shield controller feeding the health stage's shield_on qualifier.
// Turns a shield button press into a timed shield window, absorbs hits,
// breaks early after HIT_LIMIT hits, then enforces a cooldown and a finite
// budget of charges. All timing is counted in frame_tick strobes.
// Ports:
//   clock, reset   - system clock, asynchronous active-high reset
//   frame_tick     - one-cycle strobe per video frame
//   shield_req     - debounced shield button level
//   collision      - raw hit level for this tank
//   tank_dead      - death level from the health stage (overrides everything)
//   shield_on      - high exactly while ACTIVE
//   frames_left    - remaining ACTIVE/COOLDOWN frames, 0 in IDLE/DEAD
//   charges        - remaining shield uses
//   cooldown_busy  - high while in COOLDOWN
//   absorb_pulse   - one-cycle pulse per absorbed hit
module shield_ctrl #(
  parameter int ACTIVE_FRAMES   = battle_pkg::SHIELD_ACTIVE_FRAMES,
  parameter int COOLDOWN_FRAMES = battle_pkg::SHIELD_COOLDOWN_FRAMES,
  parameter int HIT_LIMIT       = battle_pkg::SHIELD_HIT_LIMIT,
  parameter int START_CHARGES   = battle_pkg::SHIELD_START_CHARGES,
  parameter int CNT_W           = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             shield_req,
  input  logic             collision,
  input  logic             tank_dead,
  output logic             shield_on,
  output logic [CNT_W-1:0] frames_left,
  output logic [1:0]       charges,
  output logic             cooldown_busy,
  output logic             absorb_pulse
);

  import battle_pkg::*;

  localparam int HIT_W = $clog2(HIT_LIMIT + 1);

  shield_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       charges_nxt;
  logic [HIT_W-1:0] hit_cnt, hit_nxt, hit_inc;
  logic             absorb_nxt;
  logic             req_rise, hit_rise;
  logic             expire, brk;

  rise_detect u_req_rise (
    .clock (clock),
    .reset (reset),
    .d     (shield_req),
    .rise  (req_rise)
  );

  rise_detect u_hit_rise (
    .clock (clock),
    .reset (reset),
    .d     (collision),
    .rise  (hit_rise)
  );

  assign hit_inc = hit_cnt + HIT_W'(1);

  // State and counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      charges      <= 2'(START_CHARGES);
      hit_cnt      <= '0;
      absorb_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      charges      <= charges_nxt;
      hit_cnt      <= hit_nxt;
      absorb_pulse <= absorb_nxt;
    end
  end

  // Next-state logic; tank_dead outranks every other event
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    charges_nxt = charges;
    hit_nxt     = hit_cnt;
    absorb_nxt  = 1'b0;
    expire      = 1'b0;
    brk         = 1'b0;
    if (tank_dead) begin
      state_nxt = DEAD;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_rise && charges != 2'd0) begin
            state_nxt   = ACTIVE;
            cnt_nxt     = CNT_W'(ACTIVE_FRAMES);
            charges_nxt = charges - 2'd1;
            hit_nxt     = '0;
          end
        end
        ACTIVE: begin
          expire = frame_tick && (cnt == CNT_W'(1));
          if (hit_rise) begin
            absorb_nxt = 1'b1;
            hit_nxt    = hit_inc;
            brk        = (hit_inc >= HIT_W'(HIT_LIMIT));
          end
          // Expiry and a breaking hit together still give one COOLDOWN entry
          if (expire || brk) begin
            state_nxt = COOLDOWN;
            cnt_nxt   = CNT_W'(COOLDOWN_FRAMES);
          end else if (frame_tick) begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cnt == CNT_W'(1)) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Output decode straight off the state register
  always_comb begin
    shield_on     = (state == ACTIVE);
    cooldown_busy = (state == COOLDOWN);
    frames_left   = cnt;
  end

endmodule

// File: tb/tb_shield_ctrl.sv
// Directed testbench for shield_ctrl with small timing parameters.
module tb_shield_ctrl;

  localparam int CNT_W = 9;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             frame_tick = 1'b0;
  logic             shield_req = 1'b0;
  logic             collision = 1'b0;
  logic             tank_dead = 1'b0;
  logic             shield_on;
  logic [CNT_W-1:0] frames_left;
  logic [1:0]       charges;
  logic             cooldown_busy;
  logic             absorb_pulse;

  int n_checks = 0;
  int n_errors = 0;

  shield_ctrl #(
    .ACTIVE_FRAMES   (4),
    .COOLDOWN_FRAMES (3),
    .HIT_LIMIT       (2),
    .START_CHARGES   (2),
    .CNT_W           (CNT_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .shield_req    (shield_req),
    .collision     (collision),
    .tank_dead     (tank_dead),
    .shield_on     (shield_on),
    .frames_left   (frames_left),
    .charges       (charges),
    .cooldown_busy (cooldown_busy),
    .absorb_pulse  (absorb_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
    end
  endtask

  task automatic check_outs(input string tag, input int on, input int fl,
                            input int ch, input int busy, input int ab);
    check({tag, ".shield_on"},     int'(shield_on),     on);
    check({tag, ".frames_left"},   int'(frames_left),   fl);
    check({tag, ".charges"},       int'(charges),       ch);
    check({tag, ".cooldown_busy"}, int'(cooldown_busy), busy);
    check({tag, ".absorb_pulse"},  int'(absorb_pulse),  ab);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  initial begin
    #12 reset = 1'b0;
    check_outs("reset", 0, 0, 2, 0, 0);

    // Basic window: press, expire, cooldown, back to IDLE
    shield_req = 1'b1;
    tick();
    check_outs("raise", 1, 4, 1, 0, 0);
    frame(1);
    check("active_dec.frames_left", int'(frames_left), 3);
    frame(3);
    check_outs("expire", 0, 3, 1, 1, 0);
    // Re-press during cooldown is ignored and must not carry over
    shield_req = 1'b0;
    tick();
    shield_req = 1'b1;
    tick();
    check_outs("cd_press", 0, 3, 1, 1, 0);
    frame(2);
    check("cd_dec.frames_left", int'(frames_left), 1);
    frame(1);
    check_outs("cd_end", 0, 0, 1, 0, 0);
    tick();
    check_outs("no_carry", 0, 0, 1, 0, 0);
    shield_req = 1'b0;
    tick();

    // Two separated hits break the shield; held collision gives one pulse
    shield_req = 1'b1;
    tick();
    check_outs("raise2", 1, 4, 0, 0, 0);
    shield_req = 1'b0;
    collision = 1'b1;
    tick();
    check_outs("hit1", 1, 4, 0, 0, 1);
    tick();
    check("hold1.absorb_pulse", int'(absorb_pulse), 0);
    tick();
    check("hold2.absorb_pulse", int'(absorb_pulse), 0);
    check("hold2.shield_on", int'(shield_on), 1);
    collision = 1'b0;
    tick();
    tick();
    collision = 1'b1;
    tick();
    check_outs("hit2_break", 0, 3, 0, 1, 1);
    collision = 1'b0;
    frame(3);
    check_outs("cd2_end", 0, 0, 0, 0, 0);

    // No charges left: press in IDLE is ignored
    shield_req = 1'b1;
    tick();
    check_outs("no_charge", 0, 0, 0, 0, 0);
    shield_req = 1'b0;
    tick();

    // Death during ACTIVE overrides frame_tick and req
    pulse_reset();
    check("rst2.charges", int'(charges), 2);
    shield_req = 1'b1;
    tick();
    check_outs("raise3", 1, 4, 1, 0, 0);
    shield_req = 1'b0;
    tick();
    tank_dead = 1'b1;
    frame_tick = 1'b1;
    shield_req = 1'b1;
    tick();
    check("dead.shield_on", int'(shield_on), 0);
    check("dead.frames_left", int'(frames_left), 0);
    check("dead.cooldown_busy", int'(cooldown_busy), 0);
    tank_dead = 1'b0;
    frame_tick = 1'b0;
    shield_req = 1'b0;
    tick();
    shield_req = 1'b1;
    collision = 1'b1;
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    check("dead_hold.shield_on", int'(shield_on), 0);
    check("dead_hold.absorb_pulse", int'(absorb_pulse), 0);
    check("dead_hold.frames_left", int'(frames_left), 0);
    shield_req = 1'b0;
    collision = 1'b0;
    tick();
    pulse_reset();
    check_outs("dead_reset", 0, 0, 2, 0, 0);

    // Expiry and breaking hit in the same cycle
    shield_req = 1'b1;
    tick();
    shield_req = 1'b0;
    collision = 1'b1;
    tick();
    check("pre_hit.absorb_pulse", int'(absorb_pulse), 1);
    collision = 1'b0;
    tick();
    frame(3);
    check("pre_expire.frames_left", int'(frames_left), 1);
    frame_tick = 1'b1;
    collision = 1'b1;
    tick();
    frame_tick = 1'b0;
    check_outs("expire_break", 0, 3, 1, 1, 1);
    tick();
    check_outs("single_entry", 0, 3, 1, 1, 0);
    collision = 1'b0;
    frame(3);
    check_outs("cd3_end", 0, 0, 1, 0, 0);

    // Hit on the entry edge is not absorbed; then async reset mid-ACTIVE
    shield_req = 1'b1;
    collision = 1'b1;
    tick();
    check_outs("entry_hit", 1, 4, 0, 0, 0);
    shield_req = 1'b0;
    collision = 1'b0;
    tick();
    collision = 1'b1;
    tick();
    check("pre_rst.absorb_pulse", int'(absorb_pulse), 1);
    collision = 1'b0;
    #3 reset = 1'b1;
    #1;
    check_outs("async_rst", 0, 0, 2, 0, 0);
    #2 reset = 1'b0;
    tick();
    check_outs("post_rst", 0, 0, 2, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
